// File: rtl/bch_error_locate.sv
// Post-Chien error-location stage: marks bit positions whose Chien terms XOR to zero,
// counts located errors per block and flags blocks whose count disagrees with deg(sigma).
module bch_error_locate #(
  parameter int M    = 4,
  parameter int T    = 2,
  parameter int BITS = 1,
  localparam int W   = $clog2(T + 2)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    in_valid,
  input  logic [(T+1)*M*BITS-1:0] chien,
  input  logic [W-1:0]            deg,
  output logic [BITS-1:0]         err,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic [W-1:0]            err_count,
  output logic                    done,
  output logic                    fail
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam logic [31:0] MAX_COUNT = 32'((2 ** W) - 1);

  logic [0:0]      state;
  logic [W-1:0]    deg_latched;
  logic            accept;
  logic [BITS-1:0] err_next;
  logic [31:0]     pc;
  logic [31:0]     sum;
  logic [W-1:0]    cnt_next;
  logic [W-1:0]    deg_ref;

  // Beats outside a block (no in_first seen yet) are silently dropped.
  assign accept  = in_valid & (in_first | (state == ACTIVE));
  assign deg_ref = in_first ? deg : deg_latched;

  always_comb begin
    logic [M-1:0] acc;
    err_next = '0;
    for (int g = 0; g < BITS; g++) begin
      acc = '0;
      for (int i = 0; i < T + 1; i++) begin
        acc = acc ^ chien[g*(T+1)*M + i*M +: M];
      end
      err_next[g] = accept & (acc == '0);
    end
  end

  // Popcount plus running total, computed wide so saturation can be detected.
  always_comb begin
    pc = '0;
    for (int g = 0; g < BITS; g++) begin
      pc = pc + 32'(err_next[g]);
    end
    sum      = in_first ? pc : pc + 32'(err_count);
    cnt_next = (sum > MAX_COUNT) ? W'(MAX_COUNT) : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      deg_latched <= '0;
      err         <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      err_count   <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      err       <= err_next;
      out_valid <= accept;
      out_first <= accept & in_first;
      out_last  <= accept & in_last;
      done      <= accept & in_last;
      if (accept) begin
        err_count <= cnt_next;
        if (in_first) begin
          deg_latched <= deg;
        end
        // fail from the previous block stays visible until the next block begins.
        if (in_last) begin
          fail <= (cnt_next != deg_ref);
        end else if (in_first) begin
          fail <= 1'b0;
        end
        if (in_last) begin
          state <= IDLE;
        end else if (in_first) begin
          state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bch_error_locate.sv
// Scoreboard bench for bch_error_locate (M=4, T=2, BITS=4): the driver queues a
// hand-computed expectation per cycle and a separate monitor compares it one cycle later.
module tb_bch_error_locate;

  localparam int M    = 4;
  localparam int T    = 2;
  localparam int BITS = 4;
  localparam int W    = $clog2(T + 2);
  localparam int CW   = (T + 1) * M * BITS;

  // Z: terms 3,5,6 (XOR is zero, an error). N: terms 1,0,0 (XOR nonzero).
  localparam logic [11:0] Z = 12'h653;
  localparam logic [11:0] N = 12'h001;

  typedef struct {
    string       name;
    int          tag;
    logic [10:0] exp;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic            in_first;
  logic            in_last;
  logic            in_valid;
  logic [CW-1:0]   chien;
  logic [W-1:0]    deg;
  logic [BITS-1:0] err;
  logic            out_valid;
  logic            out_first;
  logic            out_last;
  logic [W-1:0]    err_count;
  logic            done;
  logic            fail;

  exp_t scoreboard[$];
  int   cyc;
  int   checks;
  int   failures;

  bch_error_locate #(.M(M), .T(T), .BITS(BITS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .chien     (chien),
    .deg       (deg),
    .err       (err),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .err_count (err_count),
    .done      (done),
    .fail      (fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // exp packs {out_valid, out_first, out_last, err[3:0], err_count[1:0], done, fail}.
  task automatic applyStimulus(input string name, input logic rst_n, input logic v,
                               input logic f, input logic l, input logic [CW-1:0] ch,
                               input logic [W-1:0] d, input logic [10:0] exp);
    exp_t e;
    reset_n  = rst_n;
    in_valid = v;
    in_first = f;
    in_last  = l;
    chien    = ch;
    deg      = d;
    e.name   = name;
    e.tag    = cyc;
    e.exp    = exp;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [10:0] act;
    act = {out_valid, out_first, out_last, err, err_count, done, fail};
    checks++;
    if (act !== e.exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b (v,f,l,err,cnt,done,fail)", e.name, act, e.exp);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (scoreboard.size() > 0 && scoreboard[0].tag < cyc) begin
        checkOutput(scoreboard.pop_front());
      end
    end
  end

  initial begin : driver
    cyc = 0;
    checks = 0;
    failures = 0;

    applyStimulus("reset0", 0, 0, 0, 0, '0, 2'd0, 11'b000_0000_00_0_0);
    applyStimulus("reset1", 0, 1, 1, 0, {Z, Z, Z, Z}, 2'd3, 11'b000_0000_00_0_0);

    // Single-bit detection, deg = 1
    applyStimulus("single_b1", 1, 1, 1, 0, {N, N, N, N}, 2'd1, 11'b110_0000_00_0_0);
    applyStimulus("single_b2", 1, 1, 0, 0, {N, N, N, Z}, 2'd0, 11'b100_0001_01_0_0);
    applyStimulus("single_b3", 1, 1, 0, 1, {N, N, N, N}, 2'd0, 11'b101_0000_01_1_0);

    // Degree mismatch, deg = 2; fail holds over an idle cycle
    applyStimulus("mism_b1", 1, 1, 1, 0, {N, N, N, N}, 2'd2, 11'b110_0000_00_0_0);
    applyStimulus("mism_b2", 1, 1, 0, 0, {N, N, N, Z}, 2'd0, 11'b100_0001_01_0_0);
    applyStimulus("mism_b3", 1, 1, 0, 1, {N, N, N, N}, 2'd0, 11'b101_0000_01_1_1);
    applyStimulus("mism_hold", 1, 0, 0, 0, {Z, Z, Z, Z}, 2'd0, 11'b000_0000_01_0_1);

    // Multi-bit single-beat block: groups 3 and 0 in error, deg = 2
    applyStimulus("multi", 1, 1, 1, 1, {Z, N, N, Z}, 2'd2, 11'b111_1001_10_1_0);

    // Saturation: 3 + 2 errors, count stops at 3, deg = 2 mismatches
    applyStimulus("sat_b1", 1, 1, 1, 0, {Z, Z, Z, N}, 2'd2, 11'b110_1110_11_0_0);
    applyStimulus("sat_b2", 1, 1, 0, 1, {N, N, Z, Z}, 2'd0, 11'b101_0011_11_1_1);

    // Beats without in_first are dropped; count and fail hold
    applyStimulus("drop1", 1, 1, 0, 0, {Z, Z, Z, Z}, 2'd0, 11'b000_0000_11_0_1);
    applyStimulus("drop2", 1, 1, 0, 1, {Z, Z, Z, Z}, 2'd0, 11'b000_0000_11_0_1);

    // Restart mid-block: count reloads from the new first beat
    applyStimulus("rst_b1", 1, 1, 1, 0, {N, N, N, Z}, 2'd1, 11'b110_0001_01_0_0);
    applyStimulus("rst_b2", 1, 1, 0, 0, {N, N, Z, Z}, 2'd0, 11'b100_0011_11_0_0);
    applyStimulus("rst_new", 1, 1, 1, 0, {Z, N, N, N}, 2'd2, 11'b110_1000_01_0_0);
    applyStimulus("rst_last", 1, 1, 0, 1, {N, N, N, Z}, 2'd0, 11'b101_0001_10_1_0);

    // Back-to-back two-beat blocks: done on every second cycle
    applyStimulus("b2b_a1", 1, 1, 1, 0, {N, N, N, N}, 2'd0, 11'b110_0000_00_0_0);
    applyStimulus("b2b_a2", 1, 1, 0, 1, {N, N, N, N}, 2'd0, 11'b101_0000_00_1_0);
    applyStimulus("b2b_b1", 1, 1, 1, 0, {N, N, N, Z}, 2'd1, 11'b110_0001_01_0_0);
    applyStimulus("b2b_b2", 1, 1, 0, 1, {N, N, N, N}, 2'd0, 11'b101_0000_01_1_0);

    // Reset after beat 2 of 4 aborts the block; later beats dropped, no done
    applyStimulus("abort_b1", 1, 1, 1, 0, {N, N, N, N}, 2'd1, 11'b110_0000_00_0_0);
    applyStimulus("abort_b2", 1, 1, 0, 0, {N, N, N, Z}, 2'd0, 11'b100_0001_01_0_0);
    applyStimulus("abort_rst", 0, 1, 0, 0, {Z, Z, Z, Z}, 2'd0, 11'b000_0000_00_0_0);
    applyStimulus("abort_b3", 1, 1, 0, 0, {Z, Z, Z, Z}, 2'd0, 11'b000_0000_00_0_0);
    applyStimulus("abort_b4", 1, 1, 0, 1, {Z, Z, Z, Z}, 2'd3, 11'b000_0000_00_0_0);
    applyStimulus("abort_idle", 1, 0, 0, 0, '0, 2'd0, 11'b000_0000_00_0_0);

    in_valid = 1'b0;
    for (int i = 0; i < 20 && scoreboard.size() > 0; i++) begin
      @(posedge clk);
    end
    checks++;
    if (scoreboard.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/bch_error_locate.md
# bch_error_locate

Post-Chien error-location stage for the BCH decoder. It consumes the per-bit Chien term vectors and framing strobes produced by the Chien search. For each data bit, it XORs the T+1 M-bit terms; a zero sum marks that bit position as an error. It counts located errors over the block and, at block end, compares the count against the error-locator degree from Berlekamp-Massey to flag uncorrectable blocks. Its output feeds the correction XOR against the buffered data.

## Interface
- P, `BCH_SANE: BCH parameter set. Derived values: M = `BCH_M(P)`, T = `BCH_T(P)`, W = $clog2(T+2).
- BITS, 1: data bits per cycle. Must equal the upstream Chien BITS.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- in_first  in  1  first valid Chien beat of a block.
- in_last  in  1  last valid Chien beat of a block.
- in_valid  in  1  chien bus carries a beat.
- chien  in  (T+1)*M*BITS  group g = chien[g*(T+1)*M +: (T+1)*M] holds the T+1 terms for output bit g. Group BITS-1 is the earliest bit in stream order.
- deg  in  W  degree of sigma. Sampled on a cycle with in_valid & in_first.
- err  out  BITS  err[g] = 1 means the bit for group g is in error.
- out_valid, out_first, out_last  out  1 each  in_valid, in_first, in_last delayed by one cycle.
- err_count  out  W  running count of errors located in the current block; saturates at 2^W-1.
- done  out  1  one-cycle pulse, coincident with out_last.
- fail  out  1  block uncorrectable. Valid while done = 1 and held until the next block starts.

## Operation
- FSM has two states, IDLE and ACTIVE.
  - IDLE → ACTIVE on in_valid & in_first & !in_last.
  - ACTIVE → IDLE on in_valid & in_last.
  - in_valid & in_first while ACTIVE restarts the block: deg is re-latched and the count is reloaded.
  - A single-beat block (in_first & in_last together) is processed fully and the FSM stays in IDLE.
  - In IDLE, in_valid beats without in_first are dropped: no err output, no count change, out_valid stays 0.
- Error detection: for each accepted beat, err[g] = (XOR over i = 0..T of term i of group g) == 0. When a beat is not accepted, err is 0.
- Counting:
  - pc = popcount(err_next), where err_next is the combinational err value for the current beat.
  - On a first beat, cnt_next = pc.
  - Otherwise, cnt_next = err_count + pc, saturating at 2^W-1.
- Failure check: on an accepted last beat, fail is registered as (cnt_next != deg_latched). For a single-beat block, the check uses deg directly.
- Reset (reset_n = 0 on a clock edge):
  - All outputs, err_count, deg_latched and fail go to 0.
  - FSM goes to IDLE.
  - Reset during a block aborts it. No done is produced for the aborted block.

## Timing
- Reset value of every output is 0.
- Latency is exactly one cycle. err, out_valid, out_first, out_last, err_count, done and fail for an input beat at edge k appear after edge k.
- There is no backpressure. The upstream strobes must be held to one beat per cycle. Back-to-back blocks (in_last followed immediately by in_first) are supported with zero bubble cycles.
- fail is cleared at the first beat of the next block. err_count shows that block's first-beat popcount on the following cycle.
- The combinational path is a T+1-input M-bit XOR tree, then a BITS-wide popcount, then a W-bit adder and comparator. No extra pipeline stage is added.

## Test plan
- Single-bit detection (M=4, T=2, BITS=1), 3-beat block.
  - Stimulus: beat 2 terms {0x3, 0x5, 0x6} (XOR = 0); other beats {0x1, 0, 0}; deg = 1.
  - Required: err = 0,1,0; err_count ends at 1; done pulses with out_last; fail = 0.
- Degree mismatch.
  - Stimulus: same block as above with deg = 2.
  - Required: fail = 1 with done; fail holds until the next in_first beat.
- Multi-bit beats (BITS=4).
  - Stimulus: groups 3 and 0 sum to zero in a single-beat block with in_first & in_last; deg = 2.
  - Required: err = 4'b1001; err_count = 2; done = 1; fail = 0.
- Saturation (T=2, W=2).
  - Stimulus: 5 error bits located across the block.
  - Required: err_count saturates at 3; fail = 1 for deg = 2.
- Framing robustness.
  - Stimulus: in_valid beats with no preceding in_first.
  - Required: out_valid = 0 and err_count unchanged.
  - Stimulus: a new in_first mid-block.
  - Required: count restarts at that beat's popcount.
  - Stimulus: back-to-back blocks.
  - Required: two done pulses exactly one block length apart.
- Reset mid-block.
  - Stimulus: reset_n = 0 for one cycle after beat 2 of 4.
  - Required: all outputs 0 next cycle; remaining beats are dropped; no done pulse.
